sel_nb_face: RTL and testbench

- Upstream neighbour of the face-count-to-digit translator in the dice launcher.
- Turns two raw push-buttons (plus / minus) into the selected die size NB_Face.
- The die set is stepped through with wrap-around, with synchronisation, debouncing and one step per press.
- Selection is frozen while a roll is in progress (Lock).

---
 rtl/sel_nb_face.sv | 182 ++++++++++++++++++
 tb/tb_sel_nb_face.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sel_nb_face.sv
// sel_nb_face: plus/minus push-button selector for the die size.
// Two-flop synchronisers, a debounce FSM (IDLE/DEB/HELD/REL) giving one
// step per press, and a registered face-table decode. Lock blocks presses.
// Optional auto-repeat while held: define SEL_NB_FACE_AUTOREP_EN.
module sel_nb_face #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
`ifdef SEL_NB_FACE_AUTOREP_EN
  ,
  parameter logic [23:0] REP_DELAY  = 24'd5000000,
  parameter logic [23:0] REP_PERIOD = 24'd2500000
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BP_Plus,
  input  logic       BP_Moins,
  input  logic       Lock,
  output logic [6:0] NB_Face,
  output logic [2:0] Idx_Face,
  output logic       Change
);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_REL} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync1_q, sync2_q;   // bit0 = plus, bit1 = minus
  logic [15:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;       // 1 = plus, 0 = minus
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  nb_q;
  logic        change_q, change_d;
  logic        step;
  logic        plus_s, moins_s, lat_s, oth_s;

`ifdef SEL_NB_FACE_AUTOREP_EN
  logic [23:0] rep_q, rep_d;
  logic        rep_first_q, rep_first_d;  // waiting for the initial delay
  logic        rep_stop_q, rep_stop_d;    // other button seen, no repeats
`endif

  assign plus_s  = sync2_q[0];
  assign moins_s = sync2_q[1];
  // Latched button and the opposite one, relative to the press direction.
  assign lat_s   = dir_q ? plus_s  : moins_s;
  assign oth_s   = dir_q ? moins_s : plus_s;

  function automatic logic [6:0] face_of(input logic [2:0] idx);
    case (idx)
      3'd0:    face_of = 7'd4;
      3'd1:    face_of = 7'd6;
      3'd2:    face_of = 7'd8;
      3'd3:    face_of = 7'd10;
      3'd4:    face_of = 7'd12;
      3'd5:    face_of = 7'd20;
      3'd6:    face_of = 7'd30;
      default: face_of = 7'd100;
    endcase
  endfunction

  // Two-flop synchronisers for the raw buttons.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {BP_Moins, BP_Plus};
      sync2_q <= sync1_q;
    end
  end

  // FSM state, counters, index and registered face decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      idx_q    <= 3'd0;
      nb_q     <= 7'd4;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      idx_q    <= idx_d;
      nb_q     <= face_of(idx_d);
      change_q <= change_d;
    end
  end

`ifdef SEL_NB_FACE_AUTOREP_EN
  // Auto-repeat bookkeeping registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
      rep_stop_q  <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
      rep_stop_q  <= rep_stop_d;
    end
  end
`endif

  // Next-state logic: debounce press, step once, debounce release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step    = 1'b0;
`ifdef SEL_NB_FACE_AUTOREP_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    rep_stop_d  = rep_stop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if ((plus_s ^ moins_s) && !Lock) begin
          dir_d   = plus_s;
          cnt_d   = '0;
          state_d = S_DEB;
        end
      end
      S_DEB: begin
        if (!lat_s || oth_s || Lock) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == DEB_CYCLES - 16'd1) begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = S_HELD;
`ifdef SEL_NB_FACE_AUTOREP_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
          rep_stop_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HELD: begin
        if (!plus_s && !moins_s) begin
          cnt_d   = '0;
          state_d = S_REL;
        end
`ifdef SEL_NB_FACE_AUTOREP_EN
        else if (oth_s || rep_stop_q) begin
          rep_stop_d = 1'b1;
          rep_d      = '0;
        end else if (Lock || !lat_s) begin
          rep_d = '0;
        end else if (rep_q == (rep_first_q ? REP_DELAY - 24'd1
                                           : REP_PERIOD - 24'd1)) begin
          step        = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_d = rep_q + 24'd1;
        end
`endif
      end
      default: begin  // S_REL
        if (plus_s || moins_s) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_CYCLES - 16'd1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
    // 3-bit natural wrap gives 7->0 on plus and 0->7 on minus.
    idx_d    = step ? (dir_q ? idx_q + 3'd1 : idx_q - 3'd1) : idx_q;
    change_d = step;
  end

  assign Idx_Face = idx_q;
  assign NB_Face  = nb_q;
  assign Change   = change_q;

endmodule

// File: tb/tb_sel_nb_face.sv
// Directed bench for sel_nb_face with DEB_CYCLES=4 (REP_DELAY=20,
// REP_PERIOD=8 when auto-repeat is compiled in).
module tb_sel_nb_face;
  logic       CLK = 1'b0;
  logic       RST, BP_Plus, BP_Moins, Lock;
  logic [6:0] NB_Face;
  logic [2:0] Idx_Face;
  logic       Change;

  int errors = 0;
  int checks = 0;
  int chg_cnt = 0;
  int snap;

`ifdef SEL_NB_FACE_AUTOREP_EN
  localparam int HOLD1 = 20;
  sel_nb_face #(.DEB_CYCLES(16'd4), .REP_DELAY(24'd20), .REP_PERIOD(24'd8)) dut (
`else
  localparam int HOLD1 = 30;
  sel_nb_face #(.DEB_CYCLES(16'd4)) dut (
`endif
    .CLK(CLK), .RST(RST), .BP_Plus(BP_Plus), .BP_Moins(BP_Moins),
    .Lock(Lock), .NB_Face(NB_Face), .Idx_Face(Idx_Face), .Change(Change));

  always #5 CLK = ~CLK;

  // Pre-edge value of Change: counts every cycle it was high.
  always @(posedge CLK) if (Change) chg_cnt = chg_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input bit plus, input int n);
    if (plus) BP_Plus = 1'b1; else BP_Moins = 1'b1;
    cyc(n);
    BP_Plus = 1'b0; BP_Moins = 1'b0;
    cyc(12);
  endtask

  task automatic reset_dut();
    RST = 1'b1; cyc(2); RST = 1'b0; cyc(1);
  endtask

  int exp_seq [7] = '{4, 6, 8, 10, 12, 20, 30};

  initial begin
    RST = 1'b1; BP_Plus = 1'b0; BP_Moins = 1'b0; Lock = 1'b0;
    cyc(3);
    check("rst_idx", int'(Idx_Face), 0);
    check("rst_nb", int'(NB_Face), 4);
    check("rst_change", int'(Change), 0);
    RST = 1'b0; cyc(1);

    // Clean plus press: step lands on edge 7.
    snap = chg_cnt;
    BP_Plus = 1'b1;
    cyc(6);
    check("lat_idx_e6", int'(Idx_Face), 0);
    cyc(1);
    check("lat_idx_e7", int'(Idx_Face), 1);
    check("lat_nb_e7", int'(NB_Face), 6);
    check("lat_chg_e7", int'(Change), 1);
    cyc(1);
    check("lat_chg_e8", int'(Change), 0);
    cyc(HOLD1 - 8);
    BP_Plus = 1'b0; cyc(12);
    check("hold_one_pulse", chg_cnt - snap, 1);
    check("hold_idx", int'(Idx_Face), 1);

    // Minus from reset wraps to 100, then walk up with plus.
    reset_dut();
    press(1'b0, 10);
    check("minus_wrap_idx", int'(Idx_Face), 7);
    check("minus_wrap_nb", int'(NB_Face), 100);
    for (int i = 0; i < 7; i++) begin
      press(1'b1, 10);
      check($sformatf("seq_nb_%0d", i), int'(NB_Face), exp_seq[i]);
    end
    check("seq_idx", int'(Idx_Face), 6);

    // Bouncing press then stable: one step only.
    snap = chg_cnt;
    BP_Plus = 1'b1; cyc(2);
    BP_Plus = 1'b0; cyc(1);
    BP_Plus = 1'b1; cyc(15);
    BP_Plus = 1'b0; cyc(12);
    check("bounce_idx", int'(Idx_Face), 7);
    check("bounce_nb", int'(NB_Face), 100);
    check("bounce_pulses", chg_cnt - snap, 1);

    // 3-cycle glitch alone: no step.
    snap = chg_cnt;
    press(1'b1, 3);
    check("glitch_idx", int'(Idx_Face), 7);
    check("glitch_pulses", chg_cnt - snap, 0);

    // Lock held during a long press: no step.
    snap = chg_cnt;
    Lock = 1'b1;
    press(1'b1, 30);
    Lock = 1'b0; cyc(2);
    check("lock_idx", int'(Idx_Face), 7);
    check("lock_pulses", chg_cnt - snap, 0);

    // Lock rising during debounce aborts the press.
    BP_Plus = 1'b1; cyc(4);
    Lock = 1'b1; cyc(20);
    BP_Plus = 1'b0; cyc(12);
    Lock = 1'b0; cyc(2);
    check("lock_deb_idx", int'(Idx_Face), 7);
    check("lock_deb_pulses", chg_cnt - snap, 0);

    // Both buttons together: no step.
    BP_Plus = 1'b1; BP_Moins = 1'b1; cyc(30);
    BP_Plus = 1'b0; BP_Moins = 1'b0; cyc(12);
    check("both_idx", int'(Idx_Face), 7);
    check("both_pulses", chg_cnt - snap, 0);

    // Reach Idx=5, then reset mid-debounce.
    press(1'b0, 10);
    press(1'b0, 10);
    check("pre_rst_idx", int'(Idx_Face), 5);
    check("pre_rst_nb", int'(NB_Face), 20);
    BP_Plus = 1'b1; cyc(4);
    RST = 1'b1; #1;
    check("midrst_idx", int'(Idx_Face), 0);
    check("midrst_nb", int'(NB_Face), 4);
    check("midrst_chg", int'(Change), 0);
    cyc(1);
    RST = 1'b0; BP_Plus = 1'b0; cyc(12);
    check("post_rst_idx", int'(Idx_Face), 0);

`ifdef SEL_NB_FACE_AUTOREP_EN
    // Held 60 cycles: steps at edges 7, 27, 35, 43, 51, 59.
    reset_dut();
    snap = chg_cnt;
    BP_Plus = 1'b1; cyc(26);
    check("rep_idx_e26", int'(Idx_Face), 1);
    cyc(1);
    check("rep_idx_e27", int'(Idx_Face), 2);
    cyc(33);
    BP_Plus = 1'b0; cyc(12);
    check("rep_idx", int'(Idx_Face), 6);
    check("rep_nb", int'(NB_Face), 30);
    check("rep_pulses", chg_cnt - snap, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
